// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared defaults and wrap arithmetic for the counter block.
//             counter_next() is used by the datapath and by the optional
//             checkers, so both always agree on the wrap rule.
//  Contents : COUNTER_DEF_WIDTH, COUNTER_DEF_STEP, COUNTER_DEF_RESET,
//             COUNTER_FN_W (widest counter the helper supports),
//             counter_next(cur, step, max).
//  Revision : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam int unsigned COUNTER_DEF_WIDTH = 3;
    localparam int unsigned COUNTER_DEF_STEP  = 1;
    localparam int unsigned COUNTER_DEF_RESET = 0;

    // Operand width of the helper; counters up to this width are supported.
    localparam int unsigned COUNTER_FN_W = 32;

    // Next count after 'cur'. The sum carries one extra bit so it cannot
    // overflow before the terminal-count comparison. A value already beyond
    // 'max' is treated as corrupt and returns to 0.
    function automatic logic [COUNTER_FN_W-1:0] counter_next(
        input logic [COUNTER_FN_W-1:0] cur,
        input logic [COUNTER_FN_W-1:0] step,
        input logic [COUNTER_FN_W-1:0] max
    );
        logic [COUNTER_FN_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (cur > max) begin
            return '0;
        end else if (sum > {1'b0, max}) begin
            return COUNTER_FN_W'(sum - {1'b0, max} - 33'd1);
        end else begin
            return COUNTER_FN_W'(sum);
        end
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
//  Module   : counter
//  Purpose  : Free-running synchronous up-counter. Adds STEP on every rising
//             clock edge and wraps past MAX_VALUE back through 0. No enable,
//             no load.
//  Ports    : out    [WIDTH-1:0] output  current count, straight from a flop
//             clock              input   rising-edge clock
//             reset              input   synchronous, active-high
//  Params   : WIDTH (>=1, <=32), STEP (1..2**WIDTH-1),
//             MAX_VALUE (<=2**WIDTH-1), RESET_VALUE (<=MAX_VALUE)
//  Options  : COUNTER_ASSERT_EN - compiles in simulation-only immediate
//             checks on reset value, increment and range. Has no effect on
//             the synthesised logic.
//  Revision : 1.0  initial release
// ============================================================================
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = COUNTER_DEF_WIDTH,
    parameter int unsigned STEP        = COUNTER_DEF_STEP,
    parameter int unsigned MAX_VALUE   = (32'd1 << WIDTH) - 32'd1,
    parameter int unsigned RESET_VALUE = COUNTER_DEF_RESET
) (
    output logic [WIDTH-1:0] out,
    input  logic             clock,
    input  logic             reset
);

    // Largest value representable in WIDTH bits.
    localparam longint unsigned c_FULL = (64'd1 << WIDTH) - 64'd1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > COUNTER_FN_W) begin : g_bad_width
        $error("counter: WIDTH=%0d outside 1..%0d", WIDTH, COUNTER_FN_W);
    end
    if (STEP == 0 || 64'(STEP) > c_FULL) begin : g_bad_step
        $error("counter: STEP=%0d outside 1..2**WIDTH-1", STEP);
    end
    if (64'(MAX_VALUE) > c_FULL) begin : g_bad_max
        $error("counter: MAX_VALUE=%0d exceeds 2**WIDTH-1", MAX_VALUE);
    end
    if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
        $error("counter: RESET_VALUE=%0d exceeds MAX_VALUE=%0d", RESET_VALUE, MAX_VALUE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = WIDTH'(counter_next(COUNTER_FN_W'(r_count_q),
                                        COUNTER_FN_W'(STEP),
                                        COUNTER_FN_W'(MAX_VALUE)));
    end

    // Reset wins over the increment on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count_q <= WIDTH'(RESET_VALUE);
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign out = r_count_q;

`ifdef COUNTER_ASSERT_EN
    // ------------------------------------------------------------------
    // Simulation checks: each edge looks back at what the previous edge
    // should have produced.
    // ------------------------------------------------------------------
    logic             r_chk_valid;
    logic             r_chk_reset;
    logic [WIDTH-1:0] r_chk_prev;
    logic [WIDTH-1:0] w_chk_exp;

    always_comb begin
        w_chk_exp = WIDTH'(counter_next(COUNTER_FN_W'(r_chk_prev),
                                        COUNTER_FN_W'(STEP),
                                        COUNTER_FN_W'(MAX_VALUE)));
    end

    always_ff @(posedge clock) begin
        r_chk_valid <= 1'b1;
        r_chk_reset <= reset;
        r_chk_prev  <= r_count_q;
        if (r_chk_valid === 1'b1) begin
            if (r_chk_reset === 1'b1) begin
                assert (r_count_q == WIDTH'(RESET_VALUE))
                else $error("counter @%0t: after reset expected %0d, got %0d",
                            $time, RESET_VALUE, r_count_q);
            end else if (r_chk_reset === 1'b0 && !$isunknown(r_chk_prev)) begin
                assert (r_count_q == w_chk_exp)
                else $error("counter @%0t: after %0d expected %0d, got %0d",
                            $time, r_chk_prev, w_chk_exp, r_count_q);
            end
        end
        if (!$isunknown(r_count_q)) begin
            assert (32'(r_count_q) <= MAX_VALUE)
            else $error("counter @%0t: count %0d exceeds MAX_VALUE %0d",
                        $time, r_count_q, MAX_VALUE);
        end
    end
`endif

endmodule : counter
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter
//  Purpose  : Self-checking bench for counter. Four instances with different
//             parameter sets share one clock and reset; a reference model
//             tracks each one, and directed sequences pin down the
//             documented corner cases before a random-reset soak.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter;
    import counter_pkg::*;

    logic clk;
    logic reset;

    logic [COUNTER_DEF_WIDTH-1:0] out0;  // defaults: W3, step 1, max 7
    logic [3:0]                   out1;  // W4, max 9
    logic [2:0]                   out2;  // W3, step 3
    logic [4:0]                   out3;  // W5, step 7, max 20, reset 13

    counter u_dut0 (
        .out   (out0),
        .clock (clk),
        .reset (reset)
    );

    counter #(.WIDTH(4), .MAX_VALUE(9)) u_dut1 (
        .out   (out1),
        .clock (clk),
        .reset (reset)
    );

    counter #(.WIDTH(3), .STEP(3)) u_dut2 (
        .out   (out2),
        .clock (clk),
        .reset (reset)
    );

    counter #(.WIDTH(5), .STEP(7), .MAX_VALUE(20), .RESET_VALUE(13)) u_dut3 (
        .out   (out3),
        .clock (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance configuration and model state.
    int unsigned cfg_width[4] = '{3, 4, 3, 5};
    int unsigned cfg_step [4] = '{1, 1, 3, 7};
    int unsigned cfg_max  [4] = '{7, 9, 7, 20};
    int unsigned cfg_rst  [4] = '{0, 0, 0, 13};
    int unsigned mdl      [4] = '{0, 0, 0, 0};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Count after 'cur' with modular wrap at max+1, reduced to the counter width.
    function automatic int unsigned ref_step(input int unsigned cur, input int unsigned step,
                                             input int unsigned max, input int unsigned width);
        longint unsigned s;
        if (cur > max) return 0;
        s = longint'(cur) + longint'(step);
        if (s > longint'(max)) s = s - (longint'(max) + 1);
        return int'(s % (64'd1 << width));
    endfunction

    // One clock: drive reset, advance the models at the edge, check on the
    // following falling edge.
    task automatic tick(input logic rst_v);
        reset = rst_v;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            mdl[k] = rst_v ? cfg_rst[k] : ref_step(mdl[k], cfg_step[k], cfg_max[k], cfg_width[k]);
        end
        @(negedge clk);
        check_val("dut0_model", {29'd0, out0}, mdl[0]);
        check_val("dut1_model", {28'd0, out1}, mdl[1]);
        check_val("dut2_model", {29'd0, out2}, mdl[2]);
        check_val("dut3_model", {27'd0, out3}, mdl[3]);
    endtask

    int unsigned exp_s1[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int unsigned exp_s5[8]  = '{3, 6, 1, 4, 7, 2, 5, 0};

    initial begin
        reset = 1'b1;

        // Single reset edge, then the default sequence and the step-3 sequence.
        tick(1'b1);
        check_val("s1_reset_d0", {29'd0, out0}, 32'd0);
        check_val("s1_reset_d3", {27'd0, out3}, 32'd13);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            check_val("s1_seq_d0", {29'd0, out0}, exp_s1[i]);
            if (i < 8) check_val("s5_seq_d2", {29'd0, out2}, exp_s5[i]);
        end

        // Reset held for three edges, then the first increment.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check_val("s2_hold_d0", {29'd0, out0}, 32'd0);
        end
        tick(1'b0);
        check_val("s2_first_inc_d0", {29'd0, out0}, 32'd1);

        // Reset asserted while the default counter shows 5.
        tick(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0);
        check_val("s3_pre_d0", {29'd0, out0}, 32'd5);
        tick(1'b1);
        check_val("s3_override_d0", {29'd0, out0}, 32'd0);

        // Decimal counter: 0..9 then back to 0, never 10 or above.
        for (int i = 1; i <= 22; i++) begin
            tick(1'b0);
            check_val("s4_seq_d1", {28'd0, out1}, 32'(i % 10));
        end

        // Random resets with a low assertion probability.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_counter
`default_nettype wire
